uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-002 SHALL have parameter DATA_W, default 4: payload nibble width fed to the Hamming(7,4) transmitter.
REQ-003 SHALL have parameter WDOG_CYCLES, default 1024: tx_done timeout in clk cycles; only used when UART_SCHED_WDOG_EN is defined.
REQ-004 SHALL have port clk  input  1: clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port ena  input  1: global enable; low freezes all state.
REQ-007 SHALL have port req_valid  input  NREQ: per-requester frame request.
REQ-008 SHALL have port req_data  input  NREQ*DATA_W: payloads; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port req_ready  output  NREQ: one-hot acceptance pulse.
REQ-010 SHALL have port tx_start  output  1: one-cycle launch pulse to the transmitter.
REQ-011 SHALL have port tx_data  output  DATA_W: registered payload presented to the transmitter.
REQ-012 SHALL have port tx_busy  input  1: transmitter currently sending.
REQ-013 SHALL have port tx_done  input  1: one-cycle frame-complete pulse from the transmitter.
REQ-014 SHALL have port grant_id  output  $clog2(NREQ): index of the current or most recent winner.
REQ-015 SHALL have port busy  output  1: high whenever the FSM is not in IDLE.
REQ-016 SHALL have port err_timeout  output  1: sticky watchdog error flag.

Function
REQ-017 SHALL implement FSM states IDLE, GRANT, LAUNCH and WAIT.
REQ-018 SHALL go IDLE->GRANT when ena & |req_valid & !tx_busy, registering the round-robin winner into grant_id.
REQ-019 SHALL search round-robin starting at last_grant+1 modulo NREQ; lowest index after the pointer wins.
REQ-020 SHALL, in GRANT, assert req_ready[grant_id] for exactly one cycle, capture the winner's payload into tx_data, and go to LAUNCH.
REQ-021 SHALL, if req_valid[grant_id] is low in GRANT, return to IDLE with req_ready low, no data capture and no pointer update.
REQ-022 SHALL, in LAUNCH, assert tx_start for one cycle and go to WAIT.
REQ-023 SHALL, in WAIT, set last_grant<=grant_id on tx_done and go to IDLE; the next arbitration occurs no earlier than the following cycle.
REQ-024 SHALL give a latency of 1 cycle from req_valid in IDLE to req_ready, and 2 cycles to tx_start.
REQ-025 SHALL gate req_ready and tx_start with ena; while ena is low, the FSM, counters and tx_data hold, and tx_done is ignored.
REQ-026 SHALL ignore tx_done outside WAIT.
REQ-027 SHALL hold tx_data and grant_id stable from GRANT until the next GRANT.

Reset
REQ-028 SHALL, on rst_n low at any time (including mid-frame), set state=IDLE, req_ready=0, tx_start=0, tx_data=0, grant_id=0, err_timeout=0, and watchdog count=0.
REQ-029 SHALL reset last_grant to NREQ-1 so requester 0 has first priority.

Configuration
REQ-030 SHALL, with UART_SCHED_WDOG_EN defined, count WAIT cycles from 0; on reaching WDOG_CYCLES-1 without tx_done it SHALL set err_timeout, advance last_grant and go to IDLE.
REQ-031 SHALL, with UART_SCHED_WDOG_EN defined, clear err_timeout only on reset.
REQ-032 SHALL, without UART_SCHED_WDOG_EN, tie err_timeout to 0, instantiate no counter, and wait indefinitely in WAIT.

Structure
REQ-033 SHALL take the FSM state enum and default NREQ/DATA_W constants from shared package uart_pkg.
REQ-034 SHALL place the round-robin picker (request vector + pointer -> one-hot/index) in sub-module uart_rr_pick, which is purely combinational.

Verification
REQ-035 SHALL cover: reset, then req_valid=4'b0001 with payload 4'hA -> req_ready[0] at +1 cycle, tx_start at +2 cycles, tx_data=4'hA.
REQ-036 SHALL cover: req_valid=4'b1111 held across 4 frames -> grant_id sequence 0,1,2,3.
REQ-037 SHALL cover: tx_busy=1 with req_valid=4'b0100 -> no req_ready until tx_busy falls, then grant_id=2.
REQ-038 SHALL cover: req_valid[1] dropped during GRANT -> no req_ready, back to IDLE, next winner still 1.
REQ-039 SHALL cover: rst_n pulsed low in WAIT -> all outputs reset, and the next request from requester 3 with 0 also valid -> grant_id=0.
REQ-040 SHALL cover: with UART_SCHED_WDOG_EN and WDOG_CYCLES=16, no tx_done -> err_timeout=1 after 16 WAIT cycles, FSM in IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit scheduler slice: the scheduler
// FSM state encoding and the default requester count / payload width.
// No ports (package).
package uart_pkg;

    localparam int NREQ_DEFAULT   = 4;
    localparam int DATA_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_WAIT   = 2'd3
    } sched_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick
// Purely combinational round-robin picker. The search begins at the entry
// just after the last winner (wrapping modulo NREQ), so the last winner has
// the lowest priority on the next pick.
// Ports:
//   req_i       NREQ-bit request vector
//   ptr_i       index of the previous winner
//   grant_oh_o  one-hot winner (all zero when no request)
//   grant_idx_o index of the winner (zero when no request)
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ  = NREQ_DEFAULT,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_oh_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Walk offsets 1..NREQ from the pointer; the first requesting entry wins.
    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found            = 1'b1;
                grant_idx_o      = cand;
                grant_oh_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Round-robin scheduler that lets NREQ requesters share one Hamming(7,4)
// UART transmitter. A winner is picked in IDLE, acknowledged and its payload
// captured in GRANT, launched in LAUNCH, and the FSM then waits in WAIT for
// the transmitter's frame-complete pulse.
// Optional feature macro: UART_SCHED_WDOG_EN adds a WAIT-state watchdog of
// WDOG_CYCLES cycles that sets a sticky err_timeout and abandons the frame.
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   ena          global enable; low freezes all state and masks pulses
//   req_valid    per-requester frame request
//   req_data     packed payloads, requester i at [i*DATA_W +: DATA_W]
//   req_ready    one-hot acceptance pulse
//   tx_start     one-cycle launch pulse to the transmitter
//   tx_data      registered payload for the transmitter
//   tx_busy      transmitter busy; blocks new arbitration
//   tx_done      one-cycle frame-complete pulse
//   grant_id     index of the current or most recent winner
//   busy         FSM is not in IDLE
//   err_timeout  sticky watchdog error (0 without the watchdog)
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int          NREQ        = NREQ_DEFAULT,
    parameter int          DATA_W      = DATA_W_DEFAULT,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic                     err_timeout
);

    localparam int IDX_W = $clog2(NREQ);

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] grant_id_q, grant_id_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;

    logic [NREQ-1:0]   pick_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic              winner_valid;
    logic [DATA_W-1:0] winner_data;

    uart_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i       (req_valid),
        .ptr_i       (last_grant_q),
        .grant_oh_o  (pick_oh),
        .grant_idx_o (pick_idx)
    );

    assign winner_valid = req_valid[grant_id_q];
    assign winner_data  = req_data[grant_id_q*DATA_W +: DATA_W];

`ifdef UART_SCHED_WDOG_EN
    localparam int CNT_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             err_q, err_d;
    logic             wdog_hit;

    assign wdog_hit = (wdog_q == CNT_W'(WDOG_CYCLES - 1));

    // Watchdog counts consecutive WAIT cycles from 0 and fires on the last
    // one unless tx_done arrives; the error flag is cleared only by reset.
    always_comb begin
        wdog_d = wdog_q;
        err_d  = err_q;
        if (ena) begin
            if (state_q == ST_WAIT && !tx_done) begin
                if (wdog_hit) begin
                    wdog_d = '0;
                    err_d  = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end else begin
                wdog_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    // Next-state logic. Everything holds while ena is low, which also makes
    // tx_done invisible outside an enabled WAIT cycle.
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        tx_data_d    = tx_data_q;
        if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (|pick_oh && !tx_busy) begin
                        state_d    = ST_GRANT;
                        grant_id_d = pick_idx;
                    end
                end
                ST_GRANT: begin
                    // A winner that withdrew its request forfeits the slot
                    // without moving the round-robin pointer.
                    if (winner_valid) begin
                        state_d   = ST_LAUNCH;
                        tx_data_d = winner_data;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        state_d      = ST_IDLE;
                        last_grant_d = grant_id_q;
                    end
`ifdef UART_SCHED_WDOG_EN
                    else if (wdog_hit) begin
                        state_d      = ST_IDLE;
                        last_grant_d = grant_id_q;
                    end
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Reset puts the pointer on the last requester so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= IDX_W'(NREQ - 1);
            tx_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            tx_data_q    <= tx_data_d;
        end
    end

    // Acknowledge pulse is only raised for a winner that is still requesting.
    always_comb begin
        req_ready = '0;
        if (ena && state_q == ST_GRANT && winner_valid) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    assign tx_start = ena && (state_q == ST_LAUNCH);
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
// Directed bench for uart_tx_scheduler (NREQ=4, DATA_W=4, WDOG_CYCLES=16).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_uart_tx_scheduler;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [3:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;

    uart_tx_scheduler #(
        .NREQ        (4),
        .DATA_W      (4),
        .WDOG_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [15:0] data);
        req_valid = valid;
        req_data  = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".busy"},      32'(busy),        32'd0);
        checkOutput({tag, ".req_ready"}, 32'(req_ready),   32'd0);
        checkOutput({tag, ".tx_start"},  32'(tx_start),    32'd0);
        checkOutput({tag, ".tx_data"},   32'(tx_data),     32'd0);
        checkOutput({tag, ".grant_id"},  32'(grant_id),    32'd0);
        checkOutput({tag, ".err"},       32'(err_timeout), 32'd0);
    endtask

    // One complete frame starting from IDLE, transmitter answering at once.
    task automatic runFrame(input string tag, input logic [3:0] valid,
                            input logic [15:0] data, input int expGrant,
                            input logic [3:0] expData, input bit holdValid);
        logic [3:0] expOh;
        expOh = 4'b0001 << expGrant;
        applyStimulus(valid, data);
        step();
        checkOutput({tag, ".ready"}, 32'(req_ready), 32'(expOh));
        checkOutput({tag, ".grant"}, 32'(grant_id),  32'(expGrant));
        step();
        checkOutput({tag, ".start"}, 32'(tx_start),  32'd1);
        checkOutput({tag, ".data"},  32'(tx_data),   32'(expData));
        if (!holdValid) applyStimulus(4'b0000, data);
        step();
        checkOutput({tag, ".wait"},  32'(busy),      32'd1);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checkOutput({tag, ".idle"},  32'(busy),      32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;

        // Reset state
        step();
        step();
        checkResetState("reset");
        rst_n = 1'b1;
        step();
        checkOutput("reset.idle", 32'(busy), 32'd0);

        // Single requester 0: ready at +1, start at +2, payload A
        applyStimulus(4'b0001, 16'h000A);
        step();
        checkOutput("basic.ready",  32'(req_ready), 32'b0001);
        checkOutput("basic.grant",  32'(grant_id),  32'd0);
        checkOutput("basic.nostart", 32'(tx_start), 32'd0);
        step();
        checkOutput("basic.start",  32'(tx_start),  32'd1);
        checkOutput("basic.noready", 32'(req_ready), 32'd0);
        checkOutput("basic.data",   32'(tx_data),   32'hA);
        applyStimulus(4'b0000, 16'h000A);
        step();
        checkOutput("basic.startoff", 32'(tx_start), 32'd0);
        checkOutput("basic.wait",   32'(busy),      32'd1);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checkOutput("basic.idle",   32'(busy),      32'd0);

        // Pointer now at 0; only requester 3 -> moves pointer to 3
        runFrame("only3", 4'b1000, 16'h4321, 3, 4'h4, 1'b0);

        // All requesting, held across four frames: 0,1,2,3
        runFrame("rr0", 4'b1111, 16'h4321, 0, 4'h1, 1'b1);
        runFrame("rr1", 4'b1111, 16'h4321, 1, 4'h2, 1'b1);
        runFrame("rr2", 4'b1111, 16'h4321, 2, 4'h3, 1'b1);
        runFrame("rr3", 4'b1111, 16'h4321, 3, 4'h4, 1'b0);

        // Transmitter busy blocks arbitration
        tx_busy = 1'b1;
        applyStimulus(4'b0100, 16'h0C00);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("txbusy.noready", 32'(req_ready), 32'd0);
            checkOutput("txbusy.idle",    32'(busy),      32'd0);
        end
        tx_busy = 1'b0;
        runFrame("txbusy", 4'b0100, 16'h0C00, 2, 4'hC, 1'b0);

        // Requester 1 withdraws during GRANT (pointer at 2)
        applyStimulus(4'b0010, 16'h0050);
        step();
        checkOutput("drop.grant", 32'(grant_id), 32'd1);
        applyStimulus(4'b0000, 16'h0050);
        #1;
        checkOutput("drop.noready", 32'(req_ready), 32'd0);
        step();
        checkOutput("drop.idle",    32'(busy),      32'd0);
        checkOutput("drop.nostart", 32'(tx_start),  32'd0);
        checkOutput("drop.datahold", 32'(tx_data),  32'hC);
        // Pointer still 2: search 3,0,1 picks 1 ahead of 2
        runFrame("afterdrop", 4'b0110, 16'h0760, 1, 4'h6, 1'b0);

        // Enable low freezes GRANT and masks tx_done in WAIT
        applyStimulus(4'b0100, 16'h0700);
        step();
        checkOutput("ena.ready", 32'(req_ready), 32'b0100);
        ena = 1'b0;
        #1;
        checkOutput("ena.masked", 32'(req_ready), 32'd0);
        step();
        step();
        checkOutput("ena.hold.busy",  32'(busy),     32'd1);
        checkOutput("ena.hold.start", 32'(tx_start), 32'd0);
        checkOutput("ena.hold.grant", 32'(grant_id), 32'd2);
        ena = 1'b1;
        #1;
        checkOutput("ena.ready2", 32'(req_ready), 32'b0100);
        step();
        checkOutput("ena.start", 32'(tx_start), 32'd1);
        checkOutput("ena.data",  32'(tx_data),  32'h7);
        applyStimulus(4'b0000, 16'h0700);
        step();
        ena     = 1'b0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        ena     = 1'b1;
        checkOutput("ena.donemasked", 32'(busy), 32'd1);
        step();
        checkOutput("ena.stillwait", 32'(busy), 32'd1);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checkOutput("ena.idle", 32'(busy), 32'd0);

        // Reset in WAIT, then requester 0 regains first priority
        applyStimulus(4'b1000, 16'h9000);
        step();
        checkOutput("midrst.grant", 32'(grant_id), 32'd3);
        step();
        applyStimulus(4'b0000, 16'h9000);
        step();
        checkOutput("midrst.wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkResetState("midrst");
        step();
        rst_n = 1'b1;
        runFrame("postrst", 4'b1001, 16'h900B, 0, 4'hB, 1'b0);

        // Transmitter never answers
        applyStimulus(4'b0001, 16'h0001);
        step();
        checkOutput("wdog.grant", 32'(grant_id), 32'd0);
        step();
        checkOutput("wdog.start", 32'(tx_start), 32'd1);
        applyStimulus(4'b0000, 16'h0001);
        step();
        for (int i = 0; i < 15; i++) step();
        checkOutput("wdog.pre.busy", 32'(busy),        32'd1);
        checkOutput("wdog.pre.err",  32'(err_timeout), 32'd0);
        step();
`ifdef UART_SCHED_WDOG_EN
        checkOutput("wdog.err",    32'(err_timeout), 32'd1);
        checkOutput("wdog.idle",   32'(busy),        32'd0);
        step();
        checkOutput("wdog.sticky", 32'(err_timeout), 32'd1);
`else
        checkOutput("wdog.off.err",  32'(err_timeout), 32'd0);
        checkOutput("wdog.off.busy", 32'(busy),        32'd1);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        checkOutput("wdog.off.idle", 32'(busy), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
